// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu memory path.
package cpu_pkg;

  // Access size encodings on ls_size; 2'd3 is treated like a word.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Top two RAM address bits that select the IO region.
  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StIoWait,
    StRun,
    StDone
  } mem_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } mem_owner_e;

  // Number of bus bytes for a size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests onto
// the 8-bit RAM/HCI bus and sequences multi-byte accesses.
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 17
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_clear,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] extract_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  mem_state_e  state_q, state_d;
  mem_owner_e  owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] wdata_q, wdata_d;
  // iss: byte on mem_a; a_v: that byte will be sampled at the next edge;
  // s_v: the last edge sampled a byte, its data is on mem_din now (index cap).
  logic [1:0]  iss_q, iss_d;
  logic        a_v_q, a_v_d;
  logic        s_v_q, s_v_d;
  logic        reiss_q, reiss_d;
  logic [2:0]  cap_q, cap_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic        mem_wr_q, mem_wr_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic [31:0] merged;
  logic [2:0]  cap_inc;
  logic [2:0]  last_idx;

  // Next-state, bus sequencing and completion.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    n_d        = n_q;
    wdata_d    = wdata_q;
    iss_d      = iss_q;
    a_v_d      = a_v_q;
    s_v_d      = s_v_q;
    reiss_d    = reiss_q;
    cap_d      = cap_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_wr_d   = mem_wr_q;
    mem_dout_d = mem_dout_q;
    if_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_done_d  = 1'b0;
    ls_rdata_d = ls_rdata_q;

    merged   = s_v_q ? merge_byte(buf_q, cap_q[1:0], mem_din) : buf_q;
    cap_inc  = cap_q + {2'b00, s_v_q};
    last_idx = n_q - 3'd1;

    unique case (state_q)
      StIdle: begin
        mem_a_d    = '0;
        mem_wr_d   = 1'b0;
        mem_dout_d = '0;
        if (rdy_in && (ls_req || (if_req && !if_clear))) begin
          owner_d = ls_req ? OWN_LS : OWN_IF;
          wr_d    = ls_req && ls_wr;
          addr_d  = ls_req ? ls_addr : if_addr;
          n_d     = ls_req ? size_bytes(ls_size) : 3'd4;
          wdata_d = ls_wdata;
          iss_d   = '0;
          cap_d   = '0;
          a_v_d   = 1'b0;
          s_v_d   = 1'b0;
          reiss_d = 1'b0;
          buf_d   = '0;
          if (wr_d && addr_d[RAM_ADDR_WIDTH -: 2] == IO_REGION && io_buffer_full) begin
            state_d = StIoWait;
          end else begin
            state_d    = StRun;
            a_v_d      = 1'b1;
            mem_a_d    = addr_d;
            mem_wr_d   = wr_d;
            mem_dout_d = wr_d ? wdata_d[7:0] : 8'h00;
          end
        end
      end

      StIoWait: begin
        mem_wr_d = 1'b0;
        if (rdy_in && !io_buffer_full) begin
          state_d    = StRun;
          a_v_d      = 1'b1;
          mem_a_d    = addr_q;
          mem_wr_d   = 1'b1;
          mem_dout_d = wdata_q[7:0];
        end
      end

      StRun: begin
        if (wr_q) begin
          // A paused write simply stays on the bus until an rdy edge commits it.
          if (rdy_in) begin
            if ({1'b0, iss_q} == last_idx) begin
              state_d    = StDone;
              mem_wr_d   = 1'b0;
              mem_a_d    = '0;
              mem_dout_d = '0;
              ls_done_d  = 1'b1;
            end else begin
              iss_d      = iss_q + 2'd1;
              mem_a_d    = addr_q + {30'b0, iss_d};
              mem_dout_d = extract_byte(wdata_q, iss_d);
            end
          end
        end else begin
          // Data from the last valid sample always lands, paused or not.
          if (s_v_q) begin
            buf_d = merged;
            cap_d = cap_inc;
          end
          if (rdy_in) begin
            if (cap_inc == n_q) begin
              state_d = StDone;
              mem_a_d = '0;
              a_v_d   = 1'b0;
              s_v_d   = 1'b0;
              if (owner_q == OWN_IF) begin
                if_done_d = 1'b1;
                if_data_d = merged;
              end else begin
                ls_done_d  = 1'b1;
                ls_rdata_d = merged;
              end
            end else begin
              s_v_d = a_v_q;
              if (reiss_q) begin
                mem_a_d = addr_q + {30'b0, iss_q};
                a_v_d   = 1'b1;
                reiss_d = 1'b0;
              end else if (a_v_q) begin
                if ({1'b0, iss_q} == last_idx) begin
                  a_v_d = 1'b0;
                end else begin
                  iss_d   = iss_q + 2'd1;
                  mem_a_d = addr_q + {30'b0, iss_d};
                end
              end
            end
          end else begin
            // The byte on mem_a was not sampled: drive it again after the pause.
            s_v_d = 1'b0;
            if (a_v_q) begin
              a_v_d   = 1'b0;
              reiss_d = 1'b1;
            end
          end
        end
      end

      StDone: begin
        state_d    = StIdle;
        mem_a_d    = '0;
        mem_wr_d   = 1'b0;
        mem_dout_d = '0;
      end
    endcase

    // Fetch squash wins over everything for a fetch-owned access, even a pause.
    if (if_clear && owner_q == OWN_IF && state_q != StIdle) begin
      state_d    = StIdle;
      mem_a_d    = '0;
      mem_wr_d   = 1'b0;
      mem_dout_d = '0;
      if_done_d  = 1'b0;
      if_data_d  = if_data_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      owner_q    <= OWN_IF;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      n_q        <= '0;
      wdata_q    <= '0;
      iss_q      <= '0;
      a_v_q      <= 1'b0;
      s_v_q      <= 1'b0;
      reiss_q    <= 1'b0;
      cap_q      <= '0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      if_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      wdata_q    <= wdata_d;
      iss_q      <= iss_d;
      a_v_q      <= a_v_d;
      s_v_q      <= s_v_d;
      reiss_q    <= reiss_d;
      cap_q      <= cap_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_wr_q   <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_wr   = mem_wr_q;
  assign mem_dout = mem_dout_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a simple byte RAM and IO sink.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_clear = 1'b0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_wr = 1'b0;
  logic [1:0]  ls_size = 2'd0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_done;
  logic [31:0] ls_rdata;

  logic        preload = 1'b1;
  logic [7:0]  ram [0:65535];
  int          io_count = 0;
  logic [7:0]  io_last = 8'h00;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_clear       (if_clear),
    .if_done        (if_done),
    .if_data        (if_data),
    .ls_req         (ls_req),
    .ls_wr          (ls_wr),
    .ls_size        (ls_size),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_done        (ls_done),
    .ls_rdata       (ls_rdata)
  );

  // Bus model: samples mem_a at rdy edges, data valid the following cycle.
  // While rdy is low the bus belongs to HCI and mem_din carries junk.
  always @(posedge clk) begin
    if (preload) begin
      ram[16'h0000] <= 8'hEF; ram[16'h0001] <= 8'hBE; ram[16'h0002] <= 8'hAD;
      ram[16'h0003] <= 8'hDE;
      ram[16'h0100] <= 8'h13; ram[16'h0101] <= 8'h05; ram[16'h0102] <= 8'h10;
      ram[16'h0103] <= 8'h00;
      ram[16'h0400] <= 8'h11; ram[16'h0401] <= 8'h22; ram[16'h0402] <= 8'h33;
      ram[16'h0403] <= 8'h44;
      ram[16'h2000] <= 8'h00; ram[16'h2001] <= 8'h00; ram[16'h2002] <= 8'h00;
      ram[16'h3000] <= 8'h00; ram[16'h3001] <= 8'h00; ram[16'h3002] <= 8'h00;
      ram[16'h3003] <= 8'h00;
    end else if (rdy) begin
      if (mem_wr) begin
        if (mem_a[17:16] == 2'b11) begin
          io_count <= io_count + 1;
          io_last  <= mem_dout;
        end else begin
          ram[mem_a[15:0]] <= mem_dout;
        end
      end
      mem_din <= ram[mem_a[15:0]];
    end else begin
      mem_din <= 8'h5A;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    preload = 1'b0;
    vectors++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_bus: got a=%h wr=%b dout=%h want 0/0/0", mem_a, mem_wr, mem_dout);
    end
    vectors++;
    if (if_done !== 1'b0 || ls_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got if_done=%b ls_done=%b want 0/0", if_done, ls_done);
    end
    vectors++;
    if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got if_data=%h ls_rdata=%h want 0/0", if_data, ls_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0 || if_done !== 1'b0 || ls_done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got a=%h wr=%b ifd=%b lsd=%b want all 0",
               mem_a, mem_wr, if_done, ls_done);
    end
  endtask

  task automatic test_fetch();
    int lat;
    bit wr_seen;
    logic [31:0] exp_a;
    lat = 0;
    wr_seen = 1'b0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h100;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_wr) wr_seen = 1'b1;
      if (k <= 4) begin
        exp_a = 32'h100 + 32'(k - 1);
        vectors++;
        if (mem_a !== exp_a) begin
          miscompares++;
          $display("FAIL fetch_addr: cycle %0d got %h want %h", k, mem_a, exp_a);
        end
      end
      if (if_done) begin
        lat = k;
        if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    vectors++;
    if (lat != 6) begin
      miscompares++;
      $display("FAIL fetch_latency: got %0d want 6", lat);
    end
    vectors++;
    if (if_data !== 32'h00100513) begin
      miscompares++;
      $display("FAIL fetch_data: got %h want 00100513", if_data);
    end
    vectors++;
    if (wr_seen) begin
      miscompares++;
      $display("FAIL fetch_no_write: got mem_wr=1 want 0");
    end
    @(negedge clk);
    vectors++;
    if (if_done !== 1'b0 || mem_a !== 32'h0) begin
      miscompares++;
      $display("FAIL fetch_pulse: got if_done=%b a=%h want 0/0", if_done, mem_a);
    end
  endtask

  task automatic test_store_half();
    int done_k;
    int wr_cycles;
    done_k = 0;
    wr_cycles = 0;
    @(negedge clk);
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd1;
    ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 30 && done_k == 0; k++) begin
      @(negedge clk);
      if (mem_wr) wr_cycles++;
      if (k == 1 || k == 2) begin
        vectors++;
        if (mem_wr !== 1'b1 || mem_a !== (k == 1 ? 32'h2000 : 32'h2001) ||
            mem_dout !== (k == 1 ? 8'hEF : 8'hBE)) begin
          miscompares++;
          $display("FAIL store_byte: cycle %0d got wr=%b a=%h d=%h", k, mem_wr, mem_a, mem_dout);
        end
      end
      if (ls_done) begin
        done_k = k;
        ls_req = 1'b0;
        vectors++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin
          miscompares++;
          $display("FAIL store_done_bus: got wr=%b a=%h want 0/0", mem_wr, mem_a);
        end
      end
    end
    ls_req = 1'b0; ls_wr = 1'b0;
    vectors++;
    if (done_k != 3) begin
      miscompares++;
      $display("FAIL store_latency: got %0d want 3", done_k);
    end
    vectors++;
    if (wr_cycles != 2) begin
      miscompares++;
      $display("FAIL store_wr_cycles: got %0d want 2", wr_cycles);
    end
    vectors++;
    if ({ram[16'h2001], ram[16'h2000]} !== 16'hBEEF || ram[16'h2002] !== 8'h00) begin
      miscompares++;
      $display("FAIL store_ram: got %h%h next=%h want BEEF next=00",
               ram[16'h2001], ram[16'h2000], ram[16'h2002]);
    end
  endtask

  task automatic test_io_stall();
    int base;
    int wr_k;
    int done_k;
    int stall_wr;
    base = io_count;
    wr_k = 0;
    done_k = 0;
    stall_wr = 0;
    @(negedge clk);
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0;
    ls_addr = 32'h30000; ls_wdata = 32'h00000041;
    for (int k = 1; k <= 30 && done_k == 0; k++) begin
      @(negedge clk);
      if (k <= 5 && mem_wr) stall_wr++;
      if (k == 5) io_buffer_full = 1'b0;
      if (k > 5 && mem_wr && wr_k == 0) wr_k = k;
      if (ls_done) begin
        done_k = k;
        ls_req = 1'b0;
      end
    end
    ls_req = 1'b0; ls_wr = 1'b0;
    vectors++;
    if (stall_wr != 0) begin
      miscompares++;
      $display("FAIL io_stall_wr: got %0d write cycles during stall want 0", stall_wr);
    end
    vectors++;
    if (wr_k != 6 || done_k != 7) begin
      miscompares++;
      $display("FAIL io_timing: got wr cycle %0d done %0d want 6/7", wr_k, done_k);
    end
    vectors++;
    if (io_count - base != 1 || io_last !== 8'h41) begin
      miscompares++;
      $display("FAIL io_write: got %0d writes last=%h want 1 write of 41",
               io_count - base, io_last);
    end
  endtask

  task automatic test_priority();
    int ls_k;
    int if_k;
    ls_k = 0;
    if_k = 0;
    @(negedge clk);
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h400;
    if_req = 1'b1; if_addr = 32'h0;
    for (int k = 1; k <= 40 && if_k == 0; k++) begin
      @(negedge clk);
      if (ls_done) begin
        ls_k = k;
        ls_req = 1'b0;
      end
      if (if_done) begin
        if_k = k;
        if_req = 1'b0;
      end
    end
    ls_req = 1'b0;
    if_req = 1'b0;
    vectors++;
    if (ls_k != 6 || ls_rdata !== 32'h44332211) begin
      miscompares++;
      $display("FAIL prio_load: got done %0d data %h want 6 44332211", ls_k, ls_rdata);
    end
    vectors++;
    if (if_k != 13 || if_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL prio_fetch: got done %0d data %h want 13 deadbeef", if_k, if_data);
    end
  endtask

  task automatic test_pause();
    int lat;
    lat = 0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h100;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 3) rdy = 1'b0;
      if (k == 6) rdy = 1'b1;
      if (k == 4 || k == 7) begin
        vectors++;
        if (mem_a !== 32'h102) begin
          miscompares++;
          $display("FAIL pause_addr_hold: cycle %0d got %h want 00000102", k, mem_a);
        end
      end
      if (if_done) begin
        lat = k;
        if_req = 1'b0;
      end
    end
    rdy = 1'b1;
    if_req = 1'b0;
    vectors++;
    if (lat != 10) begin
      miscompares++;
      $display("FAIL pause_latency: got %0d want 10", lat);
    end
    vectors++;
    if (if_data !== 32'h00100513) begin
      miscompares++;
      $display("FAIL pause_data: got %h want 00100513", if_data);
    end
  endtask

  task automatic test_clear();
    int bad;
    int lat;
    bad = 0;
    lat = 0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    if_clear = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    if_clear = 1'b0;
    vectors++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_abort: got a=%h wr=%b want 0/0", mem_a, mem_wr);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if_done || mem_a !== 32'h0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL clear_no_done: got %0d busy cycles want 0", bad);
    end
    // Clear while idle blocks acceptance for that edge only.
    if_req = 1'b1;
    if_clear = 1'b1;
    @(negedge clk);
    if_clear = 1'b0;
    vectors++;
    if (mem_a !== 32'h0) begin
      miscompares++;
      $display("FAIL clear_idle_block: got a=%h want 0", mem_a);
    end
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (if_done) begin
        lat = k;
        if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    vectors++;
    if (lat != 6 || if_data !== 32'h00100513) begin
      miscompares++;
      $display("FAIL clear_then_fetch: got done %0d data %h want 6 00100513", lat, if_data);
    end
    // Clear has no effect on a load/store access.
    lat = 0;
    @(negedge clk);
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h401;
    if_clear = 1'b1;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (ls_done) begin
        lat = k;
        ls_req = 1'b0;
      end
    end
    ls_req = 1'b0;
    if_clear = 1'b0;
    vectors++;
    if (lat != 3 || ls_rdata !== 32'h00000022) begin
      miscompares++;
      $display("FAIL clear_ls_byte: got done %0d data %h want 3 00000022", lat, ls_rdata);
    end
  endtask

  task automatic test_reset_mid_store();
    bit done_seen;
    done_seen = 1'b0;
    @(negedge clk);
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2;
    ls_addr = 32'h3000; ls_wdata = 32'h44332211;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (mem_wr !== 1'b1 || mem_dout !== 8'h33 || mem_a !== 32'h3002) begin
      miscompares++;
      $display("FAIL rst_pre: got wr=%b a=%h d=%h want 1 00003002 33", mem_wr, mem_a, mem_dout);
    end
    rst_n = 1'b0;
    ls_req = 1'b0;
    ls_wr = 1'b0;
    #1;
    vectors++;
    if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_async: got wr=%b a=%h d=%h want 0/0/0", mem_wr, mem_a, mem_dout);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ls_done) done_seen = 1'b1;
    end
    vectors++;
    if (ram[16'h3000] !== 8'h11 || ram[16'h3001] !== 8'h22 ||
        ram[16'h3002] !== 8'h00 || ram[16'h3003] !== 8'h00 || done_seen) begin
      miscompares++;
      $display("FAIL rst_partial: got %h %h %h %h done=%b want 11 22 00 00 done=0",
               ram[16'h3000], ram[16'h3001], ram[16'h3002], ram[16'h3003], done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_half();
    test_io_stall();
    test_priority();
    test_pause();
    test_clear();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
